// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared pipeline constants and the multiply-sequencer state encoding
package hazard_ctrl_pkg;
  localparam int REG_W       = 5;
  localparam int MUL_LAT_DEF = 4;
  localparam int CD_W        = 4;
  typedef enum logic {IDLE, MUL_BUSY} state_e;
endpackage

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard unit producing stall/flush/freeze controls and a saturating stall counter
//   in:  clk, rst (async, active high), D-stage rs/rt, E-stage load flag and destination,
//        taken branch in D, multiply in D, I/D-cache miss
//   out: oStall_F, oStall_D, oFlush_D, oFlush_E, oFreeze, oMulBusy, oStallCnt
module hazard_ctrl import hazard_ctrl_pkg::*; #(
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] iRs_RegD,
  input  logic [REG_W-1:0] iRt_RegD,
  input  logic             iMemRead_RegE,
  input  logic [REG_W-1:0] iwsel_RegE,
  input  logic             iBranchTaken_RegD,
  input  logic             iMulStart_RegD,
  input  logic             iICacheStall,
  input  logic             iDCacheStall,
  output logic             oStall_F,
  output logic             oStall_D,
  output logic             oFlush_D,
  output logic             oFlush_E,
  output logic             oFreeze,
  output logic             oMulBusy,
  output logic [CNT_W-1:0] oStallCnt
);
  state_e            state_q, state_d;
  logic [CD_W-1:0]   cd_q, cd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              freeze, load_use, busy;
  always_comb begin
    freeze   = iICacheStall | iDCacheStall;
    load_use = iMemRead_RegE && iwsel_RegE != '0 &&
               (iwsel_RegE == iRs_RegD || iwsel_RegE == iRt_RegD);
    busy     = state_q == MUL_BUSY;
    oFreeze  = freeze;
    oStall_F = freeze | load_use | busy;
    oStall_D = oStall_F;
    // a frozen pipeline keeps every register, so no bubbles may be written
    oFlush_E = !freeze && (load_use || busy);
    // branch operands are not valid while D is held, so the redirect waits
    oFlush_D = iBranchTaken_RegD && !oStall_D;
    oMulBusy = busy;
    state_d  = state_q;
    cd_d     = cd_q;
    if (!freeze) begin
      // a pending load-use keeps the multiply from starting until its operand is ready
      if (!busy && iMulStart_RegD && !load_use) begin
        state_d = MUL_BUSY;
        cd_d    = CD_W'(MUL_LAT - 1);
      end else if (busy) begin
        state_d = cd_q == '0 ? IDLE : MUL_BUSY;
        cd_d    = cd_q == '0 ? cd_q : cd_q - 1'b1;
      end
    end
    cnt_d     = (oStall_F && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    oStallCnt = cnt_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cd_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cd_q    <= cd_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter MUL_LAT, default 4: cycles a multiply holds the D stage (legal range 2..15).
REQ-002 SHALL have parameter CNT_W, default 16: width of the stall-cycle performance counter.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port iRs_RegD, input, 5 bits: rs field of the instruction in D.
REQ-006 SHALL have port iRt_RegD, input, 5 bits: rt field of the instruction in D.
REQ-007 SHALL have port iMemRead_RegE, input, 1 bit: the instruction in E is a load.
REQ-008 SHALL have port iwsel_RegE, input, 5 bits: destination register of the instruction in E.
REQ-009 SHALL have port iBranchTaken_RegD, input, 1 bit: branch or jump resolved taken in D.
REQ-010 SHALL have port iMulStart_RegD, input, 1 bit: the instruction in D is a multiply.
REQ-011 SHALL have port iICacheStall, input, 1 bit: I-cache miss pending.
REQ-012 SHALL have port iDCacheStall, input, 1 bit: D-cache miss pending.
REQ-013 SHALL have port oStall_F, output, 1 bit: hold the PC.
REQ-014 SHALL have port oStall_D, output, 1 bit: hold the IF/ID register.
REQ-015 SHALL have port oFlush_D, output, 1 bit: write a bubble into IF/ID.
REQ-016 SHALL have port oFlush_E, output, 1 bit: write a bubble into ID/EX.
REQ-017 SHALL have port oFreeze, output, 1 bit: hold every pipeline register (cache miss).
REQ-018 SHALL have port oMulBusy, output, 1 bit: multiply sequencing in progress.
REQ-019 SHALL have port oStallCnt, output, CNT_W bits: saturating count of cycles with oStall_F=1.

Function
REQ-020 SHALL assert oFreeze combinationally whenever iICacheStall or iDCacheStall is 1; while oFreeze=1, oFlush_D and oFlush_E SHALL be 0, oStall_F and oStall_D SHALL be 1, and the FSM state and countdown SHALL hold.
REQ-021 SHALL detect load-use when iMemRead_RegE=1, iwsel_RegE!=0, and iwsel_RegE equals iRs_RegD or iRt_RegD; the response is oStall_F=1, oStall_D=1 and oFlush_E=1 in the same cycle.
REQ-022 SHALL assert oFlush_D for exactly the cycle in which iBranchTaken_RegD=1, unless oStall_D=1 in that cycle, in which case the flush is suppressed because the branch operands are not yet valid.
REQ-023 SHALL implement a registered FSM with states IDLE and MUL_BUSY and a 4-bit countdown register.
REQ-024 In IDLE, with iMulStart_RegD=1 and no freeze: next state MUL_BUSY, countdown loaded with MUL_LAT-1.
REQ-025 In MUL_BUSY: oMulBusy=1, oStall_F=1, oStall_D=1 and oFlush_E=1; the countdown decrements each unfrozen cycle.
REQ-026 In MUL_BUSY with countdown=0 and no freeze: next state IDLE, so the multiply stalls D for exactly MUL_LAT cycles in total.
REQ-027 A load-use condition coinciding with iMulStart_RegD SHALL take priority: the FSM stays in IDLE until the load-use condition clears.
REQ-028 Stall and flush outputs SHALL be combinational from state and inputs, with no added latency.
REQ-029 oStallCnt SHALL increment by 1 in each cycle with oStall_F=1 and SHALL saturate at all-ones (no wrap).

Reset
REQ-030 rst=1 SHALL force state IDLE, countdown 0, oStallCnt 0 and oMulBusy 0 asynchronously, including mid-multiply.
REQ-031 After reset with all inputs 0, every stall, flush and freeze output SHALL be 0.

Structure
REQ-032 The FSM state encoding and the MUL_LAT default SHALL live in the shared pipeline package; the register-number width (5) is a package constant.
REQ-033 SHALL be a single module with no sub-module; the load-use compare is inline.

Verification
REQ-034 Load-use: iMemRead_RegE=1, iwsel_RegE=8, iRt_RegD=8 -> oStall_F=oStall_D=oFlush_E=1 in the same cycle; iwsel_RegE=0 -> all three 0.
REQ-035 Multiply: iMulStart_RegD pulsed one cycle, MUL_LAT=4 -> oMulBusy=1 for exactly 4 cycles, then 0; oStallCnt=4.
REQ-036 Freeze mid-multiply: iDCacheStall=1 for 3 cycles during MUL_BUSY -> oMulBusy lasts 7 cycles; oFlush_E=0 during the freeze.
REQ-037 Branch plus load-use in the same cycle -> oFlush_D=0, stall asserted; the next cycle, with load-use cleared and the branch still taken -> oFlush_D=1.
REQ-038 rst pulsed during cycle 2 of a multiply -> oMulBusy=0 and oStallCnt=0 immediately, with no clock edge needed.
REQ-039 Force oStall_F=1 for 70000 cycles with CNT_W=16 -> oStallCnt holds at 65535.
